// File: rtl/cmos_pkg.sv
// Shared types and constants for the synthetic camera stream generator:
// timing states, test-pattern codes and the RGB565 colour-bar palette.
package cmos_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } cmos_state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_COUNT = 2'd3;

    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] YELLOW  = 16'hFFE0;
    localparam logic [15:0] CYAN    = 16'h07FF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] MAGENTA = 16'hF81F;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] BLACK   = 16'h0000;

    // Left-to-right order of the eight vertical bars.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = WHITE;
            3'd1:    c = YELLOW;
            3'd2:    c = CYAN;
            3'd3:    c = GREEN;
            3'd4:    c = MAGENTA;
            3'd5:    c = RED;
            3'd6:    c = BLUE;
            default: c = BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cmos_pattern_pixel.sv
// Combinational test-pattern pixel: maps the pixel coordinate, the in-frame
// pixel index and the selected pattern to an RGB565 value.
module cmos_pattern_pixel
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] pix_idx,
    input  logic [1:0]  pattern,
    output logic [15:0] data
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [15:0] bar_idx;
    logic        unused_y;

    assign bar_idx  = x / 16'(BAR_W);
    // Only y[5] drives the checker; the rest of the line index is not needed.
    assign unused_y = &{1'b0, y[15:6], y[4:0]};

    always_comb begin
        data = BLACK;
        case (pattern)
            PAT_BARS:  data = (bar_idx > 16'd7) ? BLACK : bar_colour(bar_idx[2:0]);
            PAT_RAMP:  data = {x[7:3], x[7:2], x[7:3]};
            PAT_CHECK: data = (x[5] ^ y[5]) ? WHITE : BLACK;
            default:   data = pix_idx;
        endcase
    end

endmodule

// File: rtl/cmos_stream_gen.sv
// Synthetic DVP camera source: parameterised vsync/href frame timing with a
// selectable RGB565 test pattern, clocked by camera 0's pixel clock.
module cmos_stream_gen
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 720,
    parameter int V_SYNC   = 4,
    parameter int V_BACK   = 16,
    parameter int V_FRONT  = 8
) (
    input  logic        sys_rst_n,
    input  logic        cmos0_pclk,
    input  logic        gen_en,
    input  logic [1:0]  pattern_sel,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output cmos_state_e dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int LMAX_A  = (V_ACTIVE > V_SYNC) ? V_ACTIVE : V_SYNC;
    localparam int LMAX_B  = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int LMAX    = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
    localparam int LW      = (LMAX > 1) ? $clog2(LMAX) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

    // href acts as a valid with no ready: the stream cannot be back-pressured,
    // so every href-high cycle carries one pixel that must be taken.

    cmos_state_e state, state_n, next_phase;
    logic [HW-1:0] h_cnt, h_n;
    logic [LW-1:0] line_cnt, line_n, last_line;
    logic [1:0]    pat_q;
    logic [15:0]   pix_cnt;
    logic [15:0]   pix_data;
    logic          vsync_n, href_n, frame_end_n, vsync_entry;

    always_comb begin
        last_line  = '0;
        next_phase = IDLE;
        case (state)
            VSYNC: begin
                last_line  = LW'(V_SYNC - 1);
                next_phase = (V_BACK > 0) ? VBACK : ACTIVE;
            end
            VBACK: begin
                last_line  = LW'(V_BACK - 1);
                next_phase = ACTIVE;
            end
            ACTIVE: begin
                last_line  = LW'(V_ACTIVE - 1);
                if (V_FRONT > 0) next_phase = VFRONT;
                else             next_phase = gen_en ? VSYNC : IDLE;
            end
            VFRONT: begin
                last_line  = LW'(V_FRONT - 1);
                next_phase = gen_en ? VSYNC : IDLE;
            end
            default: begin
                last_line  = '0;
                next_phase = IDLE;
            end
        endcase
    end

    always_comb begin
        state_n = state;
        h_n     = h_cnt;
        line_n  = line_cnt;
        if (state == IDLE) begin
            if (gen_en) state_n = VSYNC;
        end else if (h_cnt == H_LAST) begin
            h_n = '0;
            if (line_cnt == last_line) begin
                line_n  = '0;
                state_n = next_phase;
            end else begin
                line_n = line_cnt + 1'b1;
            end
        end else begin
            h_n = h_cnt + 1'b1;
        end
    end

    // Outputs are registered from the next-cycle position, so they line up
    // with the state/counters they describe without any skew.
    always_comb begin
        vsync_n     = (state_n == VSYNC);
        href_n      = (state_n == ACTIVE) && (h_n < HW'(H_ACTIVE));
        vsync_entry = (state_n == VSYNC) && (state != VSYNC);
        if (V_FRONT > 0)
            frame_end_n = (state_n == VFRONT) && (h_n == H_LAST) &&
                          (line_n == LW'(V_FRONT - 1));
        else
            frame_end_n = (state_n == ACTIVE) && (h_n == H_LAST) &&
                          (line_n == LW'(V_ACTIVE - 1));
    end

    cmos_pattern_pixel #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel (
        .x       (16'(h_n)),
        .y       (16'(line_n)),
        .pix_idx (pix_cnt),
        .pattern (pat_q),
        .data    (pix_data)
    );

    always_ff @(posedge cmos0_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            h_cnt      <= '0;
            line_cnt   <= '0;
            pat_q      <= PAT_BARS;
            pix_cnt    <= '0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            h_cnt      <= h_n;
            line_cnt   <= line_n;
            cmos_vsync <= vsync_n;
            cmos_href  <= href_n;
            cmos_data  <= href_n ? pix_data : 16'h0000;
            frame_done <= frame_end_n;
            if (frame_end_n) frame_cnt <= frame_cnt + 16'd1;
            if (vsync_entry) begin
                pat_q   <= pattern_sel;
                pix_cnt <= '0;
            end else if (href_n) begin
                pix_cnt <= pix_cnt + 16'd1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cmos_stream_gen.sv
// Directed bench for cmos_stream_gen: a frame model pushes per-cycle expected
// outputs to a queue and a negedge monitor pops and compares them.
module tb_cmos_stream_gen;
    import cmos_pkg::*;

    localparam int H_ACTIVE  = 16;
    localparam int H_BLANK   = 4;
    localparam int V_ACTIVE  = 4;
    localparam int V_SYNC    = 1;
    localparam int V_BACK    = 1;
    localparam int V_FRONT   = 1;
    localparam int H_TOTAL   = H_ACTIVE + H_BLANK;
    localparam int FRAME_CYC = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * H_TOTAL;
    localparam int EW        = 35;

    logic        cmos0_pclk  = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        gen_en      = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        cmos_vsync, cmos_href, frame_done;
    logic [15:0] cmos_data, frame_cnt;
    logic [2:0]  dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [15:0]   exp_fc   = 16'd0;
    logic [15:0]   bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                   16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    cmos_stream_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) dut (
        .sys_rst_n   (sys_rst_n),
        .cmos0_pclk  (cmos0_pclk),
        .gen_en      (gen_en),
        .pattern_sel (pattern_sel),
        .cmos_vsync  (cmos_vsync),
        .cmos_href   (cmos_href),
        .cmos_data   (cmos_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 cmos0_pclk = ~cmos0_pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_pixel(input int pat, input int x, input int y, input int pix);
        logic [15:0] xv;
        logic [15:0] yv;
        xv = 16'(x);
        yv = 16'(y);
        case (pat)
            0:       return bar_tab[x / (H_ACTIVE / 8)];
            1:       return {xv[7:3], xv[7:2], xv[7:3]};
            2:       return (xv[5] ^ yv[5]) ? 16'hFFFF : 16'h0000;
            default: return 16'(pix);
        endcase
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 1'b0, 16'h0000, 1'b0, exp_fc});
    endtask

    // Expected outputs for the first ncyc cycles of a frame, starting at VSYNC.
    task automatic push_frame(input int pat, input int ncyc);
        int pix;
        pix = 0;
        for (int c = 0; c < ncyc; c++) begin
            logic vs, hr, fd;
            logic [15:0] d;
            int a;
            vs = 1'b0; hr = 1'b0; fd = 1'b0; d = 16'h0000;
            if (c < V_SYNC * H_TOTAL) begin
                vs = 1'b1;
            end else if (c >= (V_SYNC + V_BACK) * H_TOTAL &&
                         c < (V_SYNC + V_BACK + V_ACTIVE) * H_TOTAL) begin
                a = c - (V_SYNC + V_BACK) * H_TOTAL;
                if ((a % H_TOTAL) < H_ACTIVE) begin
                    hr = 1'b1;
                    d  = model_pixel(pat, a % H_TOTAL, a / H_TOTAL, pix);
                    pix++;
                end
            end
            if (c == FRAME_CYC - 1) begin
                fd = 1'b1;
                exp_fc = exp_fc + 16'd1;
            end
            exp_q.push_back({vs, hr, d, fd, exp_fc});
        end
    endtask

    task automatic step();
        @(posedge cmos0_pclk);
        #2;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vsync"}, 32'(cmos_vsync), 32'd0);
        check({tag, "_href"},  32'(cmos_href),  32'd0);
        check({tag, "_data"},  32'(cmos_data),  32'd0);
        check({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check({tag, "_fcnt"},  32'(frame_cnt),  32'd0);
        check({tag, "_state"}, 32'(dbg_state),  32'(IDLE));
    endtask

    always @(negedge cmos0_pclk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("vsync",      32'(cmos_vsync), 32'(mon_e[34]));
            check("href",       32'(cmos_href),  32'(mon_e[33]));
            check("data",       32'(cmos_data),  32'(mon_e[32:17]));
            check("frame_done", 32'(frame_done), 32'(mon_e[16]));
            check("frame_cnt",  32'(frame_cnt),  32'(mon_e[15:0]));
        end
    end

    initial begin
        // Reset state
        #12;
        check_all_zero("reset");
        step();
        sys_rst_n = 1'b1;
        step();
        check_all_zero("post_reset_idle");

        // Single bars frame, then back to idle
        pattern_sel = 2'd0;
        gen_en = 1'b1;
        push_idle(1);
        push_frame(0, FRAME_CYC);
        push_idle(8);
        repeat (5) step();
        gen_en = 1'b0;
        drain(1000);
        check("s1_state_idle", 32'(dbg_state), 32'(IDLE));

        // Three back-to-back pixel-counter frames
        pattern_sel = 2'd3;
        gen_en = 1'b1;
        push_idle(1);
        for (int f = 0; f < 3; f++) push_frame(3, FRAME_CYC);
        push_idle(8);
        repeat (2 * FRAME_CYC + 5) step();
        gen_en = 1'b0;
        drain(1000);

        // Ramp frame with run request dropped at the second active line
        pattern_sel = 2'd1;
        gen_en = 1'b1;
        push_idle(1);
        push_frame(1, FRAME_CYC);
        push_idle(10);
        repeat ((V_SYNC + V_BACK + 1) * H_TOTAL + 1) step();
        gen_en = 1'b0;
        drain(1000);
        check("s4_state_idle", 32'(dbg_state), 32'(IDLE));

        // Pattern change mid-frame applies only to the following frame
        pattern_sel = 2'd0;
        gen_en = 1'b1;
        push_idle(1);
        push_frame(0, FRAME_CYC);
        push_frame(2, FRAME_CYC);
        push_idle(5);
        repeat (70) step();
        pattern_sel = 2'd2;
        repeat (80) step();
        gen_en = 1'b0;
        drain(1000);

        // Asynchronous reset in the middle of the active region
        pattern_sel = 2'd3;
        gen_en = 1'b1;
        push_idle(1);
        push_frame(3, 49);
        repeat (50) step();
        check("s6_pre_reset_queue", 32'(exp_q.size()), 32'd0);
        check("s6_href_before_reset", 32'(cmos_href), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_fc = 16'd0;
        repeat (3) step();
        check_all_zero("held_reset");
        sys_rst_n = 1'b1;
        push_idle(1);
        push_frame(3, FRAME_CYC);
        push_idle(5);
        repeat (5) step();
        gen_en = 1'b0;
        drain(1000);
        check("s6_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cmos_stream_gen.md
Name: cmos_stream_gen

Overview:
- Synthetic camera source that transmits the DVP-style stream the splicing/fusion path consumes: cmos_vsync, cmos_href and 16-bit RGB565 cmos_data.
- Line and frame timing come from parameters; the pixel content is a selectable test pattern.
- Drives either camera input of the splicer in place of a real sensor, for bring-up and bench stimulus.
- Runs in the cmos0_pclk domain, so frames are generated pixel-synchronous to camera 0.

Parameters:
- H_ACTIVE, 640, pixels per line with href high; must be a multiple of 8.
- H_BLANK, 160, href-low cycles after each active line; must be >= 1.
- V_ACTIVE, 720, active lines per frame.
- V_SYNC, 4, lines (H_TOTAL cycles each) with vsync high.
- V_BACK, 16, lines between vsync falling and the first active line.
- V_FRONT, 8, lines after the last active line, before frame end.

Ports:
- sys_rst_n  input  1  asynchronous active-low reset.
- cmos0_pclk  input  1  pixel clock; every register in the block uses it.
- gen_en  input  1  run request; sampled at frame boundaries only.
- pattern_sel  input  2  0 = colour bars, 1 = ramp, 2 = checker, 3 = pixel counter.
- cmos_vsync  output  1  frame sync, active high.
- cmos_href  output  1  line valid, active high.
- cmos_data  output  16  RGB565 pixel; 16'h0000 whenever href is low.
- frame_done  output  1  one-cycle pulse on the last cycle of V_FRONT.
- frame_cnt  output  16  completed frames, wraps at 16'hFFFF.

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is cmos0_pclk. While reset is low, all outputs are 0, the state is IDLE and all counters are 0. Reset asserted mid-frame aborts the frame immediately, with no frame_done.
- Timing constants: H_TOTAL = H_ACTIVE + H_BLANK. h_cnt counts 0..H_TOTAL-1 within a line; line_cnt counts lines within a phase.
- States: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT -> (VSYNC | IDLE).
- IDLE: when gen_en is sampled 1, go to VSYNC; cmos_vsync is high starting the next cycle.
- VSYNC: cmos_vsync = 1 for exactly V_SYNC*H_TOTAL cycles.
- VBACK: lasts V_BACK*H_TOTAL cycles with vsync and href both low.
- ACTIVE: V_ACTIVE lines. In each line, href = 1 for h_cnt 0..H_ACTIVE-1, then 0 for H_BLANK cycles. Pixel coordinates are x = h_cnt and y = active line index.
- VFRONT: lasts V_FRONT*H_TOTAL cycles. On its final cycle, frame_done = 1 and frame_cnt increments.
- End of VFRONT:
  - gen_en = 1: go straight to VSYNC with no idle gap.
  - gen_en = 0: go to IDLE.
  - gen_en deasserting mid-frame never truncates the frame.
- pattern_sel is latched on entry to VSYNC and held for the whole frame. Changes mid-frame take effect at the next frame.
- All outputs are registered. cmos_data is valid in the same cycle as href and is aligned with it; there is no pipeline skew.
- Colour bars: bar = x / (H_ACTIVE/8). Bars 0..7 are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Ramp: {x[7:3], x[7:2], x[7:3]}, which wraps every 256 pixels.
- Checker: (x[5] ^ y[5]) ? FFFF : 0000.
- Pixel counter: 16-bit count of href-high cycles since the frame start. It is reset on VSYNC entry and wraps modulo 2^16.
- Zero-length phases: V_BACK = 0 or V_FRONT = 0 skips that state. Skipping V_FRONT = 0 moves frame_done/frame_cnt onto the last cycle of ACTIVE.

Decomposition:
- Package cmos_pkg holds:
  - state encoding (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - pattern codes PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_COUNT;
  - RGB565 colour constants (WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK).
- One sub-module, cmos_pattern_pixel: combinational pixel function from (x, y, pix_idx, pattern) to 16-bit data.
- The timing FSM, counters and output registers stay in cmos_stream_gen.

Test Plan:
- Bench parameters H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, V_SYNC=1, V_BACK=1, V_FRONT=1, so H_TOTAL=20 and a frame is 140 cycles.
- Scenario 1: release reset, gen_en=1, pattern 0 -> vsync high 20 cycles, then 20 low, then 4 lines of href high 16 / low 4, then 20-cycle front porch. frame_done pulses at cycle 140 of the frame; frame_cnt=1.
- Scenario 2: pattern 0 -> each active line emits FFFF x2, FFE0 x2, 07FF x2, 07E0 x2, F81F x2, F800 x2, 001F x2, 0000 x2. cmos_data = 0 during blanking.
- Scenario 3: pattern 3 over 3 back-to-back frames -> data runs 0..63 in every frame; vsync re-asserts on the cycle after frame_done; frame_cnt = 1, 2, 3.
- Scenario 4: drop gen_en at the 2nd active line -> the frame completes with all 4 lines and frame_done; the block enters IDLE with all outputs 0 and no further vsync.
- Scenario 5: change pattern_sel 0->2 mid-frame -> the current frame stays bars; the next frame is checker (all FFFF or all 0000 at this size, since x,y < 32).
- Scenario 6: assert sys_rst_n low mid-ACTIVE -> outputs go 0 asynchronously, no frame_done, frame_cnt = 0. After release with gen_en=1, a full frame starts from VSYNC.
